fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Instruction-fetch stage directly upstream of the branch decision logic. It consumes the 2-bit PCsrc next-PC select produced for the instruction in ID.
- Owns the program counter and drives a ready/valid instruction-memory request.
- Registers the fetched instruction into the IF/ID outputs.
- Handles redirects (branch/JAL/JALR), including kill of an in-flight fetch, and pipeline stalls via a one-entry skid buffer.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, value of if_inst when no valid instruction (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
PCsrc  input  2  next-PC select for instruction in ID: 00 sequential, 01 branch/JAL target, 11 JALR target, 10 reserved (treated as 00)
branch_target  input  32  PC-relative target for PCsrc=01
jalr_target  input  32  register-based target for PCsrc=11
stall  input  1  ID cannot accept a new instruction; IF/ID outputs must hold
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address
imem_ready  input  1  memory returns imem_rdata this cycle; transfer = imem_req & imem_ready
imem_rdata  input  32  fetched instruction word
if_inst  output  32  IF/ID instruction
if_pc  output  32  IF/ID PC
if_pc4  output  32  if_pc + 4 (combinational from if_pc)
if_valid  output  1  IF/ID holds a real instruction
redirect  output  1  one-cycle pulse: redirect accepted; ID/EX must flush

Behaviour:
- Reset values: state=FETCH, req_pc=RESET_PC, if_inst=NOP_INST, if_pc=0, if_valid=0, redirect=0, skid empty.
- Internal registers: req_pc, tgt_reg, skid_inst, skid_pc.
- imem_req is 0 while rst is low.
- Target selection: PCsrc=01 uses branch_target. PCsrc=11 uses {jalr_target[31:1],1'b0}. All arithmetic is mod 2^32; 0xFFFF_FFFC+4 wraps to 0.
- A redirect is accepted only when stall=0 and PCsrc is 01 or 11. Acceptance pulses redirect=1 for that cycle, registered (visible the cycle after the sampling edge).
- FETCH state: imem_req=1, imem_addr=req_pc.
  - stall=0, redirect, ready: discard rdata; req_pc<=target; if_valid<=0.
  - stall=0, redirect, !ready: tgt_reg<=target; if_valid<=0; go to DRAIN.
  - stall=0, no redirect, ready: if_inst<=rdata; if_pc<=req_pc; if_valid<=1; req_pc<=req_pc+4.
  - stall=0, no redirect, !ready: if_valid<=0 (bubble).
  - stall=1: IF/ID holds and redirect is ignored. If ready: skid<=rdata/req_pc, req_pc<=req_pc+4, go to HOLD. Otherwise stay.
- DRAIN state: imem_req=1, imem_addr=req_pc. The address must stay stable until the transfer.
  - On ready: discard rdata; req_pc<=tgt_reg; go to FETCH.
  - A new accepted redirect overwrites tgt_reg (last wins).
  - if_valid stays 0.
- HOLD state: imem_req=0.
  - While stall=1: hold everything.
  - stall=0, no redirect: if_inst/if_pc<=skid; if_valid<=1; go to FETCH.
  - stall=0, redirect: drop skid; req_pc<=target; if_valid<=0; go to FETCH.
- imem protocol: once imem_req is asserted, req and addr are held until the transfer. Req drops only on entry to HOLD, after a transfer.
- Throughput: one instruction per cycle with imem_ready tied high. Redirect penalty is one bubble.
- Reset mid-operation (any state): return to reset values immediately. Any outstanding fetch is abandoned, and the memory must tolerate abandonment on reset.

Test Plan:
- Reset then release with imem_ready=1, PCsrc=00, stall=0 -> imem_addr 0,4,8,... on consecutive cycles; if_pc 0,4,8 one cycle later; if_valid=1 from the second cycle after release; if_pc4=if_pc+4.
- At if_pc=8, drive PCsrc=01, branch_target=0x40, ready=1 -> redirect pulse; next if_valid=0; following imem_addr=0x40; then if_pc=0x40 valid.
- PCsrc=11, jalr_target=0x101, imem_ready=0 for 3 cycles -> DRAIN: imem_addr held at old req_pc for 3 cycles; on ready, response discarded; next imem_addr=0x100.
- stall=1 for 4 cycles with ready=1 -> exactly one fetch captured into skid; imem_req=0 for the rest of the stall; if_* unchanged. On stall=0, skid instruction appears, then fetch resumes at skid_pc+4 with no loss or duplication.
- stall=1 with PCsrc=01 -> no redirect pulse and req_pc unaffected.
- Assert rst low while in DRAIN -> imem_req=0, if_inst=0x00000013, if_valid=0. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch stage. Owns the program counter, issues
// ready/valid instruction-memory requests and registers the fetched word into
// the IF/ID outputs. Redirects from ID (branch/JAL/JALR) kill the in-flight
// fetch; ID stalls are absorbed by a one-entry skid buffer.
//
// Ports:
//   clk, rst             clock (rising edge), async active-low reset
//   PCsrc                next-PC select for the instruction in ID
//                        (00 seq, 01 branch/JAL, 11 JALR, 10 treated as 00)
//   branch_target        target used when PCsrc=01
//   jalr_target          target used when PCsrc=11 (bit 0 forced to 0)
//   stall                ID cannot accept; IF/ID outputs hold
//   imem_req/imem_addr   fetch request and address
//   imem_ready/rdata     transfer completes when imem_req & imem_ready
//   if_inst/if_pc/if_pc4 IF/ID instruction, PC and PC+4
//   if_valid             IF/ID holds a real instruction
//   redirect             registered pulse: redirect accepted, flush ID/EX
//
// state | meaning
// FETCH | request outstanding at req_pc, normal flow
// DRAIN | redirect accepted while fetch pending; wait for it, then jump
// HOLD  | one word parked in skid buffer while ID stalls; no request
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCsrc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic        redirect
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] req_pc;
  logic [31:0] tgt_reg;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;
  logic        redir_acc;
  logic [31:0] target;

  // PCsrc 01 and 11 both have bit 0 set; the reserved 10 falls out as sequential.
  assign redir_acc = ~stall & PCsrc[0];
  assign target    = PCsrc[1] ? {jalr_target[31:1], 1'b0} : branch_target;
  assign if_pc4    = if_pc + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (redir_acc && !imem_ready)  state_nxt = DRAIN;
        else if (stall && imem_ready)  state_nxt = HOLD;
      end
      DRAIN:   if (imem_ready) state_nxt = FETCH;
      HOLD:    if (!stall)     state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Request is gated by rst so nothing is issued while reset is held.
  always_comb begin
    imem_req  = rst && (state != HOLD);
    imem_addr = req_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_pc    <= RESET_PC;
      tgt_reg   <= 32'd0;
      skid_inst <= 32'd0;
      skid_pc   <= 32'd0;
      if_inst   <= NOP_INST;
      if_pc     <= 32'd0;
      if_valid  <= 1'b0;
      redirect  <= 1'b0;
    end else begin
      redirect <= redir_acc;
      case (state)
        FETCH: begin
          if (stall) begin
            if (imem_ready) begin
              skid_inst <= imem_rdata;
              skid_pc   <= req_pc;
              req_pc    <= req_pc + 32'd4;
            end
          end else if (redir_acc) begin
            if_valid <= 1'b0;
            if (imem_ready) req_pc  <= target;
            else            tgt_reg <= target;
          end else if (imem_ready) begin
            if_inst  <= imem_rdata;
            if_pc    <= req_pc;
            if_valid <= 1'b1;
            req_pc   <= req_pc + 32'd4;
          end else begin
            if_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if_valid <= 1'b0;
          if (redir_acc) tgt_reg <= target;
          // A redirect accepted on the draining cycle itself wins over tgt_reg.
          if (imem_ready) req_pc <= redir_acc ? target : tgt_reg;
        end
        HOLD: begin
          if (!stall) begin
            if (redir_acc) begin
              req_pc   <= target;
              if_valid <= 1'b0;
            end else begin
              if_inst  <= skid_inst;
              if_pc    <= skid_pc;
              if_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  PCsrc = 2'b00;
  logic [31:0] branch_target = 32'd0;
  logic [31:0] jalr_target = 32'd0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_inst, if_pc, if_pc4;
  logic        if_valid, redirect;
  logic        chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_pc_unit dut (
    .clk(clk), .rst(rst), .PCsrc(PCsrc), .branch_target(branch_target),
    .jalr_target(jalr_target), .stall(stall), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4), .if_valid(if_valid),
    .redirect(redirect)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Behavioural model: next fetch address, an optional pending jump target,
  // a queue of parked words, and the IF/ID contents.
  logic [31:0] m_next = 32'd0;
  logic        m_pend_v = 1'b0;
  logic [31:0] m_pend_t = 32'd0;
  logic [63:0] skid_q[$];
  logic [31:0] m_inst = NOP;
  logic [31:0] m_pc = 32'd0;
  logic        m_valid = 1'b0;
  logic        m_redir = 1'b0;
  logic        m_acc;
  logic [31:0] m_tgt;
  logic [63:0] m_w;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_next = 32'd0; m_pend_v = 1'b0; m_pend_t = 32'd0;
      skid_q.delete();
      m_inst = NOP; m_pc = 32'd0; m_valid = 1'b0; m_redir = 1'b0;
    end else begin
      m_acc   = !stall && (PCsrc == 2'b01 || PCsrc == 2'b11);
      m_tgt   = (PCsrc == 2'b01) ? branch_target : (jalr_target & 32'hFFFF_FFFE);
      m_redir = m_acc;
      if (skid_q.size() > 0) begin
        if (!stall) begin
          m_w = skid_q.pop_front();
          if (m_acc) begin
            m_next = m_tgt; m_valid = 1'b0;
          end else begin
            m_inst = m_w[63:32]; m_pc = m_w[31:0]; m_valid = 1'b1;
          end
        end
      end else if (m_pend_v) begin
        if (m_acc) m_pend_t = m_tgt;
        if (imem_ready) begin
          m_next = m_pend_t; m_pend_v = 1'b0;
        end
        m_valid = 1'b0;
      end else if (stall) begin
        if (imem_ready) begin
          skid_q.push_back({mem_word(m_next), m_next});
          m_next = m_next + 32'd4;
        end
      end else if (m_acc) begin
        m_valid = 1'b0;
        if (imem_ready) m_next = m_tgt;
        else begin m_pend_v = 1'b1; m_pend_t = m_tgt; end
      end else if (imem_ready) begin
        m_inst = mem_word(m_next); m_pc = m_next; m_valid = 1'b1;
        m_next = m_next + 32'd4;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("m_req", imem_req, rst && skid_q.size() == 0);
      if (rst && skid_q.size() == 0) chk("m_addr", imem_addr, m_next);
      chk("m_inst", if_inst, m_inst);
      chk("m_pc", if_pc, m_pc);
      chk("m_pc4", if_pc4, m_pc + 32'd4);
      chk1("m_valid", if_valid, m_valid);
      chk1("m_redirect", redirect, m_redir);
    end
  end

  // Apply inputs (at negedge+1), then advance one clock and return at negedge+1.
  task automatic drive(input logic s, input logic rdy, input logic [1:0] ps,
                       input logic [31:0] bt, input logic [31:0] jt);
    stall = s; imem_ready = rdy; PCsrc = ps; branch_target = bt; jalr_target = jt;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_en = 1'b1;
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_inst", if_inst, NOP);
    chk1("rst_valid", if_valid, 1'b0);
    chk("rst_pc", if_pc, 32'd0);
    chk1("rst_redirect", redirect, 1'b0);
    rst = 1'b1;
    #1;
    chk("first_addr", imem_addr, 32'd0);
    chk1("first_req", imem_req, 1'b1);

    // sequential stream
    repeat (3) drive(0, 1, 2'b00, 0, 0);
    chk("seq_pc", if_pc, 32'h8);
    chk("seq_addr", imem_addr, 32'hC);
    chk("seq_pc4", if_pc4, 32'hC);

    // branch redirect, one bubble
    drive(0, 1, 2'b01, 32'h40, 0);
    chk1("br_redirect", redirect, 1'b1);
    chk1("br_bubble", if_valid, 1'b0);
    chk("br_addr", imem_addr, 32'h40);
    drive(0, 1, 2'b00, 0, 0);
    chk("br_pc", if_pc, 32'h40);
    chk("br_inst", if_inst, mem_word(32'h40));
    chk1("br_redirect_off", redirect, 1'b0);

    // JALR with memory not ready -> drain
    drive(0, 0, 2'b11, 0, 32'h101);
    chk1("jalr_redirect", redirect, 1'b1);
    chk("drain_addr0", imem_addr, 32'h44);
    repeat (2) drive(0, 0, 2'b00, 0, 0);
    chk("drain_addr2", imem_addr, 32'h44);
    chk1("drain_req", imem_req, 1'b1);
    drive(0, 1, 2'b00, 0, 0);
    chk("jalr_addr", imem_addr, 32'h100);
    chk1("jalr_bubble", if_valid, 1'b0);
    drive(0, 1, 2'b00, 0, 0);
    chk("jalr_pc", if_pc, 32'h100);

    // stall with ready: one word parked, request dropped, redirect ignored
    drive(1, 1, 2'b00, 0, 0);
    chk1("stall_req", imem_req, 1'b0);
    chk("stall_pc", if_pc, 32'h100);
    drive(1, 1, 2'b01, 32'h80, 0);
    chk1("stall_noredir", redirect, 1'b0);
    repeat (2) drive(1, 1, 2'b00, 0, 0);
    chk("stall_pc_held", if_pc, 32'h100);
    drive(0, 1, 2'b00, 0, 0);
    chk("skid_pc", if_pc, 32'h104);
    chk("skid_inst", if_inst, mem_word(32'h104));
    chk("resume_addr", imem_addr, 32'h108);
    drive(0, 1, 2'b00, 0, 0);
    chk("resume_pc", if_pc, 32'h108);

    // stall without ready, branch ignored
    drive(1, 0, 2'b01, 32'h80, 0);
    chk1("stall_nr_redir", redirect, 1'b0);
    chk("stall_nr_addr", imem_addr, 32'h10C);

    // redirect while a word is parked drops it
    drive(1, 1, 2'b00, 0, 0);
    drive(0, 1, 2'b11, 0, 32'h2001);
    chk1("hold_redirect", redirect, 1'b1);
    chk("hold_tgt_addr", imem_addr, 32'h2000);
    drive(0, 1, 2'b00, 0, 0);
    chk("hold_tgt_pc", if_pc, 32'h2000);

    // address wrap
    drive(0, 1, 2'b01, 32'hFFFF_FFFC, 0);
    drive(0, 1, 2'b00, 0, 0);
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_pc4, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // two redirects during drain: last wins
    drive(0, 0, 2'b01, 32'h300, 0);
    drive(0, 0, 2'b11, 0, 32'h401);
    chk("lw_addr_held", imem_addr, 32'h0);
    drive(0, 1, 2'b00, 0, 0);
    chk("lw_addr", imem_addr, 32'h400);
    drive(0, 1, 2'b00, 0, 0);
    chk("lw_pc", if_pc, 32'h400);

    // reset asserted while draining
    drive(0, 0, 2'b01, 32'h500, 0);
    PCsrc = 2'b00;
    rst = 1'b0;
    #1;
    chk1("rd_req", imem_req, 1'b0);
    chk("rd_inst", if_inst, NOP);
    chk1("rd_valid", if_valid, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rd_restart_addr", imem_addr, 32'h0);
    drive(0, 1, 2'b00, 0, 0);
    chk("rd_restart_pc", if_pc, 32'h0);
    chk1("rd_restart_valid", if_valid, 1'b1);

    // mixed directed pattern, checked by the model every cycle
    for (int i = 0; i < 150; i++) begin
      logic [1:0] ps;
      ps = (i % 11 == 5) ? 2'b01 : (i % 13 == 7) ? 2'b11 : (i % 17 == 4) ? 2'b10 : 2'b00;
      drive((i % 7 == 2) || (i % 7 == 3) || (i % 19 == 10), (i % 3) != 0, ps,
            32'h200 + 32'(i) * 8, 32'h301 + 32'(i) * 4);
    end
    drive(0, 1, 2'b00, 0, 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
